// File: rtl/i2c_arb_pkg.sv
// Shared types and constants for the i2c_arbiter block.
package i2c_arb_pkg;

  // Widest per-request byte count the command register can hold (LEN_W must not exceed it).
  localparam int unsigned LenMaxW = 8;
  localparam int unsigned TimeoutCycDefault = 65535;

  typedef enum logic [3:0] {
    StIdle,
    StArb,
    StStart,
    StBusy,
    StXfer,
    StWaitIdle,
    StDone
  } arb_state_t;

  typedef struct packed {
    logic               rnw;
    logic [6:0]         slave_addr;
    logic [7:0]         reg_addr;
    logic [LenMaxW-1:0] len;
  } cmd_t;

endpackage

// File: rtl/i2c_arbiter_rr.sv
// Round-robin one-hot picker; the search pointer moves past the grantee on accept.
module rr_arbiter #(
  parameter int unsigned N_REQ = 4
) (
  input  logic                     clk_i,
  input  logic                     arstn_i,
  input  logic [N_REQ-1:0]         req_i,
  input  logic                     accept_i,
  output logic [N_REQ-1:0]         gnt_o,
  output logic [$clog2(N_REQ)-1:0] idx_o,
  output logic                     valid_o
);

  localparam int unsigned PtrW = $clog2(N_REQ);

  logic [PtrW-1:0] ptr_q;
  logic [PtrW-1:0] cand;
  logic            found;

  always_comb begin
    gnt_o = '0;
    idx_o = '0;
    found = 1'b0;
    cand  = '0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      cand = PtrW'((32'(ptr_q) + i) % N_REQ);
      if (!found && req_i[cand]) begin
        found       = 1'b1;
        idx_o       = cand;
        gnt_o[cand] = 1'b1;
      end
    end
    valid_o = found;
  end

  always_ff @(posedge clk_i or negedge arstn_i) begin
    if (!arstn_i) begin
      ptr_q <= '0;
    end else if (accept_i) begin
      ptr_q <= (idx_o == PtrW'(N_REQ - 1)) ? '0 : idx_o + 1'b1;
    end
  end

endmodule

// File: rtl/i2c_arbiter.sv
// Shares one i2c_master between N_REQ requesters, round-robin, one transaction per grant.
// Optional watchdog enabled by defining I2C_ARB_TIMEOUT_EN.
module i2c_arbiter
  import i2c_arb_pkg::*;
#(
  parameter int unsigned N_REQ = 4,
  parameter int unsigned LEN_W = 4
`ifdef I2C_ARB_TIMEOUT_EN
  , parameter int unsigned TIMEOUT_CYC = TimeoutCycDefault
`endif
) (
  input  logic               clk_i,
  input  logic               arstn_i,
  input  logic [N_REQ-1:0]   req_i,
  input  logic [N_REQ-1:0]   rnw_i,
  input  logic [N_REQ*7-1:0] slave_addr_i,
  input  logic [N_REQ*8-1:0] reg_addr_i,
  input  logic [N_REQ*LEN_W-1:0] len_i,
  input  logic [N_REQ*8-1:0] wdata_i,
  output logic [N_REQ-1:0]   gnt_o,
  output logic               wdata_next_o,
  output logic [7:0]         rdata_o,
  output logic               rdata_valid_o,
  output logic               done_o,
  output logic               err_o,
  output logic               mst_start_o,
  output logic               mst_rnw_o,
  output logic [6:0]         mst_slave_addr_o,
  output logic [7:0]         mst_reg_addr_o,
  output logic [7:0]         mst_wdata_o,
  output logic               mst_nack_o,
  input  logic [7:0]         mst_rdata_i,
  input  logic               mst_byte_done_i,
  input  logic               mst_ready_i
);

  localparam int unsigned PtrW = $clog2(N_REQ);

  arb_state_t       state_q, state_d;
  cmd_t             cmd_q, cmd_d;
  logic [N_REQ-1:0] gnt_q, gnt_d, pick;
  logic [PtrW-1:0]  idx_q, idx_d, pick_idx;
  logic             pick_valid, accept;
  logic [LEN_W-1:0] cnt_q, cnt_d, cnt_inc;
  logic             err_q, err_d;
  logic [7:0]       rdata_q;
  logic             rdata_valid_q, rd_byte, active, cnt_last, force_nack;

  rr_arbiter #(
    .N_REQ(N_REQ)
  ) u_rr (
    .clk_i   (clk_i),
    .arstn_i (arstn_i),
    .req_i   (req_i),
    .accept_i(accept),
    .gnt_o   (pick),
    .idx_o   (pick_idx),
    .valid_o (pick_valid)
  );

`ifdef I2C_ARB_TIMEOUT_EN
  logic [15:0] wdog_q, wdog_d;
  logic        to_q, to_d, wdog_hit;
  assign wdog_hit   = (wdog_q == 16'(TIMEOUT_CYC));
  assign force_nack = active && to_q;
`else
  assign force_nack = 1'b0;
`endif

  assign cnt_inc = cnt_q + LEN_W'(mst_byte_done_i);

  always_comb begin
    state_d = state_q;
    cmd_d   = cmd_q;
    gnt_d   = gnt_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    err_d   = err_q;
    accept  = 1'b0;
`ifdef I2C_ARB_TIMEOUT_EN
    to_d    = to_q;
    wdog_d  = (!active || mst_byte_done_i) ? '0 : (wdog_hit ? wdog_q : wdog_q + 16'd1);
`endif
    case (state_q)
      StIdle: if (|req_i && mst_ready_i) state_d = StArb;
      StArb: begin
        if (pick_valid) begin
          accept           = 1'b1;
          gnt_d            = pick;
          idx_d            = pick_idx;
          cmd_d.rnw        = rnw_i[pick_idx];
          cmd_d.slave_addr = slave_addr_i[pick_idx*7 +: 7];
          cmd_d.reg_addr   = reg_addr_i[pick_idx*8 +: 8];
          cmd_d.len        = LenMaxW'(len_i[pick_idx*LEN_W +: LEN_W]);
          cnt_d            = '0;
          err_d            = (len_i[pick_idx*LEN_W +: LEN_W] == '0);
          state_d          = err_d ? StDone : StStart;
        end else begin
          state_d = StIdle;
        end
      end
      StStart: if (!mst_ready_i) state_d = StXfer;
      StXfer: begin
        // A byte finishing together with the ready rise still counts toward completion.
        cnt_d = cnt_inc;
        if (LenMaxW'(cnt_inc) == cmd_q.len) begin
          state_d = StWaitIdle;
        end else if (mst_ready_i) begin
          err_d   = 1'b1;
          state_d = StDone;
        end
      end
      StWaitIdle: if (mst_ready_i) state_d = StDone;
      StDone: begin
        gnt_d   = '0;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
`ifdef I2C_ARB_TIMEOUT_EN
    if (active && wdog_hit) begin
      if (!to_q) begin
        to_d    = 1'b1;
        wdog_d  = '0;
        err_d   = 1'b1;
        state_d = StWaitIdle;
      end else begin
        state_d = StDone;
      end
    end
    if (state_q == StDone) to_d = 1'b0;
`endif
  end

  always_ff @(posedge clk_i or negedge arstn_i) begin
    if (!arstn_i) begin
      state_q       <= StIdle;
      cmd_q         <= '0;
      gnt_q         <= '0;
      idx_q         <= '0;
      cnt_q         <= '0;
      err_q         <= 1'b0;
      rdata_q       <= '0;
      rdata_valid_q <= 1'b0;
`ifdef I2C_ARB_TIMEOUT_EN
      wdog_q        <= '0;
      to_q          <= 1'b0;
`endif
    end else begin
      state_q       <= state_d;
      cmd_q         <= cmd_d;
      gnt_q         <= gnt_d;
      idx_q         <= idx_d;
      cnt_q         <= cnt_d;
      err_q         <= err_d;
      rdata_valid_q <= rd_byte;
      if (rd_byte) rdata_q <= mst_rdata_i;
`ifdef I2C_ARB_TIMEOUT_EN
      wdog_q        <= wdog_d;
      to_q          <= to_d;
`endif
    end
  end

  assign active   = state_q inside {StStart, StXfer, StWaitIdle};
  assign rd_byte  = (state_q == StXfer) && cmd_q.rnw && mst_byte_done_i;
  assign cnt_last = (LenMaxW'(cnt_q) == cmd_q.len - LenMaxW'(1));

  assign gnt_o            = (state_q == StArb) ? pick : (active ? gnt_q : '0);
  assign wdata_next_o     = (state_q == StXfer) && !cmd_q.rnw && mst_byte_done_i;
  assign rdata_o          = rdata_q;
  assign rdata_valid_o    = rdata_valid_q;
  assign done_o           = (state_q == StDone);
  assign err_o            = done_o && err_q;
  assign mst_start_o      = (state_q == StStart);
  assign mst_rnw_o        = active && cmd_q.rnw;
  assign mst_slave_addr_o = active ? cmd_q.slave_addr : '0;
  assign mst_reg_addr_o   = active ? cmd_q.reg_addr : '0;
  assign mst_wdata_o      = active ? wdata_i[idx_q*8 +: 8] : '0;
  assign mst_nack_o       = ((state_q == StXfer) && cnt_last) || (state_q == StWaitIdle) ||
                            force_nack;

endmodule

// File: tb/tb_i2c_arbiter.sv
// Directed bench for i2c_arbiter; the i2c_master side is driven by hand, cycle by cycle.
module tb_i2c_arbiter;

  localparam int unsigned NReq = 4;
  localparam int unsigned LenW = 4;

  logic                 clk, arstn;
  logic [NReq-1:0]      req, rnw;
  logic [NReq*7-1:0]    saddr;
  logic [NReq*8-1:0]    raddr, wdata;
  logic [NReq*LenW-1:0] len;
  logic [NReq-1:0]      gnt;
  logic                 wdata_next, rdata_valid, done, err;
  logic [7:0]           rdata;
  logic                 mst_start, mst_rnw, mst_nack;
  logic [6:0]           mst_saddr;
  logic [7:0]           mst_raddr, mst_wdata, mst_rdata;
  logic                 mst_byte_done, mst_ready;

  int vectors;
  int miscompares;
  logic [7:0] rexp [3];
  logic [3:0] rr_order [4];

  i2c_arbiter #(
    .N_REQ(NReq),
    .LEN_W(LenW)
  ) dut (
    .clk_i           (clk),
    .arstn_i         (arstn),
    .req_i           (req),
    .rnw_i           (rnw),
    .slave_addr_i    (saddr),
    .reg_addr_i      (raddr),
    .len_i           (len),
    .wdata_i         (wdata),
    .gnt_o           (gnt),
    .wdata_next_o    (wdata_next),
    .rdata_o         (rdata),
    .rdata_valid_o   (rdata_valid),
    .done_o          (done),
    .err_o           (err),
    .mst_start_o     (mst_start),
    .mst_rnw_o       (mst_rnw),
    .mst_slave_addr_o(mst_saddr),
    .mst_reg_addr_o  (mst_raddr),
    .mst_wdata_o     (mst_wdata),
    .mst_nack_o      (mst_nack),
    .mst_rdata_i     (mst_rdata),
    .mst_byte_done_i (mst_byte_done),
    .mst_ready_i     (mst_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic set_req(input int k, input logic r, input logic [6:0] sa, input logic [7:0] ra,
                         input logic [3:0] l, input logic [7:0] wd);
    rnw[k]          = r;
    saddr[k*7 +: 7] = sa;
    raddr[k*8 +: 8] = ra;
    len[k*4 +: 4]   = l;
    wdata[k*8 +: 8] = wd;
  endtask

  function automatic logic [63:0] all_outs();
    return 64'({gnt, wdata_next, rdata, rdata_valid, done, err, mst_start, mst_rnw, mst_saddr,
                mst_raddr, mst_wdata, mst_nack});
  endfunction

  initial begin
    vectors = 0;
    miscompares = 0;
    rexp = '{8'h11, 8'h22, 8'h33};
    rr_order = '{4'b0001, 4'b0010, 4'b1000, 4'b0001};
    arstn = 1'b0; req = '0; rnw = '0; saddr = '0; raddr = '0; len = '0; wdata = '0;
    mst_rdata = '0; mst_byte_done = 1'b0; mst_ready = 1'b1;
    tick(); tick();
    chk("reset_outs", all_outs(), 64'd0);
    arstn = 1'b1;
    tick();
    chk("idle_gnt", 64'(gnt), 64'd0);

    // Requester 0 writes two bytes.
    set_req(0, 1'b0, 7'h50, 8'h10, 4'd2, 8'hA5);
    req = 4'b0001;
    tick();
    chk("a_arb_gnt", 64'(gnt), 64'b0001);
    chk("a_arb_nostart", 64'(mst_start), 64'd0);
    tick();
    chk("a_start", 64'(mst_start), 64'd1);
    chk("a_saddr", 64'(mst_saddr), 64'h50);
    chk("a_raddr", 64'(mst_raddr), 64'h10);
    chk("a_rnw", 64'(mst_rnw), 64'd0);
    chk("a_wdata0", 64'(mst_wdata), 64'hA5);
    tick();
    chk("a_start_held", 64'(mst_start), 64'd1);
    mst_ready = 1'b0;
    tick();
    chk("a_start_drop", 64'(mst_start), 64'd0);
    chk("a_nack_b1", 64'(mst_nack), 64'd0);
    mst_byte_done = 1'b1; #1;
    chk("a_wnext1", 64'(wdata_next), 64'd1);
    tick();
    mst_byte_done = 1'b0; wdata[7:0] = 8'h3C; #1;
    chk("a_wnext_idle", 64'(wdata_next), 64'd0);
    chk("a_nack_b2", 64'(mst_nack), 64'd1);
    chk("a_wdata1", 64'(mst_wdata), 64'h3C);
    mst_byte_done = 1'b1; #1;
    chk("a_wnext2", 64'(wdata_next), 64'd1);
    tick();
    mst_byte_done = 1'b0;
    chk("a_nack_wait", 64'(mst_nack), 64'd1);
    chk("a_no_done", 64'(done), 64'd0);
    chk("a_gnt_wait", 64'(gnt), 64'b0001);
    mst_ready = 1'b1;
    tick();
    chk("a_done", 64'(done), 64'd1);
    chk("a_err", 64'(err), 64'd0);
    chk("a_gnt_drop", 64'(gnt), 64'd0);
    req = '0;
    tick();
    chk("a_done_pulse", 64'(done), 64'd0);

    // Requester 2 reads three bytes.
    set_req(2, 1'b1, 7'h2A, 8'h05, 4'd3, 8'h00);
    req = 4'b0100;
    tick();
    chk("b_arb_gnt", 64'(gnt), 64'b0100);
    tick();
    chk("b_rnw", 64'(mst_rnw), 64'd1);
    mst_ready = 1'b0;
    tick();
    for (int k = 0; k < 3; k++) begin
      chk("b_nack", 64'(mst_nack), 64'(k == 2));
      mst_rdata = rexp[k]; mst_byte_done = 1'b1;
      tick();
      mst_byte_done = 1'b0; mst_rdata = 8'hFF;
      chk("b_valid", 64'(rdata_valid), 64'd1);
      chk("b_rdata", 64'(rdata), 64'(rexp[k]));
      tick();
      chk("b_valid_pulse", 64'(rdata_valid), 64'd0);
    end
    chk("b_nack_wait", 64'(mst_nack), 64'd1);
    mst_ready = 1'b1;
    tick();
    chk("b_done", 64'(done), 64'd1);
    chk("b_err", 64'(err), 64'd0);
    req = '0;
    tick();

    // Asynchronous reset in the middle of a transfer; pointer was at 3, so requester 1 wins.
    set_req(1, 1'b0, 7'h33, 8'h44, 4'd4, 8'h77);
    req = 4'b0010;
    tick();
    chk("r_gnt", 64'(gnt), 64'b0010);
    tick();
    mst_ready = 1'b0;
    tick();
    mst_byte_done = 1'b1;
    tick();
    mst_byte_done = 1'b0;
    chk("r_in_xfer", 64'(gnt), 64'b0010);
    arstn = 1'b0; #1;
    chk("r_async_outs", all_outs(), 64'd0);
    tick(); tick(); tick();
    chk("r_held_outs", all_outs(), 64'd0);
    req = '0; mst_ready = 1'b1; arstn = 1'b1;
    tick();

    // Continuous requests from 0, 1 and 3; pointer restarts at 0 after reset.
    set_req(0, 1'b0, 7'h10, 8'h20, 4'd1, 8'h01);
    set_req(1, 1'b0, 7'h11, 8'h21, 4'd1, 8'h02);
    set_req(3, 1'b0, 7'h13, 8'h23, 4'd1, 8'h04);
    req = 4'b1011;
    for (int n = 0; n < 4; n++) begin
      tick();
      chk("rr_gnt", 64'(gnt), 64'(rr_order[n]));
      tick();
      chk("rr_gnt_held", 64'(gnt), 64'(rr_order[n]));
      mst_ready = 1'b0;
      tick();
      mst_byte_done = 1'b1;
      tick();
      mst_byte_done = 1'b0; mst_ready = 1'b1;
      tick();
      chk("rr_done", 64'(done), 64'd1);
      chk("rr_err", 64'(err), 64'd0);
      tick();
    end
    req = '0;
    tick();

    // Zero-length request: done with error one cycle after the grant, no start strobe.
    set_req(1, 1'b0, 7'h12, 8'h34, 4'd0, 8'h00);
    req = 4'b0010;
    tick();
    chk("z_gnt", 64'(gnt), 64'b0010);
    chk("z_nostart_arb", 64'(mst_start), 64'd0);
    tick();
    chk("z_done", 64'(done), 64'd1);
    chk("z_err", 64'(err), 64'd1);
    chk("z_nostart_done", 64'(mst_start), 64'd0);
    req = '0;
    tick();
    chk("z_nostart_idle", 64'(mst_start), 64'd0);

    // Master goes idle after one of four bytes.
    set_req(3, 1'b0, 7'h55, 8'h66, 4'd4, 8'h99);
    req = 4'b1000;
    tick();
    chk("e_gnt", 64'(gnt), 64'b1000);
    tick();
    mst_ready = 1'b0;
    tick();
    mst_byte_done = 1'b1;
    tick();
    mst_byte_done = 1'b0; mst_ready = 1'b1;
    chk("e_nack", 64'(mst_nack), 64'd0);
    tick();
    chk("e_done", 64'(done), 64'd1);
    chk("e_err", 64'(err), 64'd1);
    req = '0;
    tick();

    // Longest transfer; last byte arrives together with the ready rise.
    set_req(0, 1'b0, 7'h01, 8'h02, 4'd15, 8'h5A);
    req = 4'b0001;
    tick();
    chk("m_gnt", 64'(gnt), 64'b0001);
    tick();
    mst_ready = 1'b0;
    tick();
    for (int k = 0; k < 15; k++) begin
      chk("m_nack", 64'(mst_nack), 64'(k == 14));
      mst_byte_done = 1'b1;
      if (k == 14) mst_ready = 1'b1;
      tick();
      mst_byte_done = 1'b0;
    end
    chk("m_wait_nodone", 64'(done), 64'd0);
    chk("m_wait_nack", 64'(mst_nack), 64'd1);
    tick();
    chk("m_done", 64'(done), 64'd1);
    chk("m_err", 64'(err), 64'd0);
    req = '0;
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
